// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: shared types and opcodes for the Knight command arbiter.
// Also used by the command processor for its opcode decode.
package cmd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESENT   = 2'd1,
      WAIT_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_HOST = 2'b01,
      OWN_TOUR = 2'b10
   } owner_t;

   localparam logic [3:0] O_CALIBRATE = 4'b0010;
   localparam logic [3:0] O_MOVE      = 4'b0100;
   localparam logic [3:0] O_MOVE_F    = 4'b0101;
   localparam logic [3:0] O_TOUR_GO   = 4'b0110;

   // Cycles an accepted command may wait for its response before it is abandoned.
   function automatic logic [25:0] timeout_limit(input bit fast);
      return fast ? 26'd4095 : 26'h3FF_FFFF;
   endfunction

endpackage

// File: rtl/cmd_arb_timer.sv
// cmd_arb_timer: response timeout counter for cmd_arb.
// Counts while i_run is high and restarts from zero whenever i_run drops.
// o_expired is high during the final allowed cycle of the run.
module cmd_arb_timer
   import cmd_arb_pkg::*;
#(
   parameter int FAST_SIM = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   output logic o_expired
);

   localparam logic [25:0] LIMIT = timeout_limit(FAST_SIM != 0);

   logic [25:0] r_count;

   // Cycle counter, held at zero outside a run so every run starts fresh.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (!i_run) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 26'd1;
      end
   end

   assign o_expired = i_run && (r_count == (LIMIT - 26'd1));

endmodule

// File: rtl/cmd_arb.sv
// cmd_arb: arbitrates the host wrapper and the tour generator onto the single
// command port of the command processor, routing clear and response back to
// the owner of the grant. Optional response timeout: define CMD_ARB_TIMEOUT_EN.
module cmd_arb
   import cmd_arb_pkg::*;
#(
   parameter int FAST_SIM = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] host_cmd,
   input  logic        host_cmd_rdy,
   output logic        host_clr_cmd_rdy,
   output logic        host_resp,
   input  logic [15:0] tour_cmd,
   input  logic        tour_cmd_rdy,
   output logic        tour_clr_cmd_rdy,
   output logic        tour_resp,
   input  logic        tour_go,
   input  logic        tour_done,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [1:0]  owner,
   output logic        tour_mode,
   output logic        timeout_err
);

   state_t      r_state;
   owner_t      r_owner;
   logic        r_tour_mode;
   logic [15:0] r_cmd_hold;

   logic [15:0] w_cmd_sel;
   logic        w_rdy_sel;
   logic        w_grant_tour;
   logic        w_grant_host;
   logic        w_grant;
   logic        w_clr_route;
   logic        w_resp_route;
   logic        w_waiting;
   logic        w_expired;
   logic        w_timeout;

   // Select the owning requester's command and valid; nothing when unowned.
   always_comb begin
      w_cmd_sel = 16'h0000;
      w_rdy_sel = 1'b0;
      case (r_owner)
         OWN_HOST: begin
            w_cmd_sel = host_cmd;
            w_rdy_sel = host_cmd_rdy;
         end
         OWN_TOUR: begin
            w_cmd_sel = tour_cmd;
            w_rdy_sel = tour_cmd_rdy;
         end
         default: begin
            w_cmd_sel = 16'h0000;
            w_rdy_sel = 1'b0;
         end
      endcase
   end

   // Tour only competes while in tour mode, and then always beats the host.
   assign w_grant_tour = (r_state == IDLE) && r_tour_mode && tour_cmd_rdy;
   assign w_grant_host = (r_state == IDLE) && !w_grant_tour && host_cmd_rdy;
   assign w_grant      = w_grant_tour || w_grant_host;

   assign w_clr_route  = (r_state == PRESENT) && clr_cmd_rdy;
   assign w_resp_route = (r_state == WAIT_RESP) && send_resp;
   assign w_waiting    = (r_state == WAIT_RESP);

   // A response arriving in the expiry cycle still completes the command.
   assign w_timeout    = w_expired && !send_resp;

`ifdef CMD_ARB_TIMEOUT_EN
   logic r_timeout_err;

   cmd_arb_timer #(
      .FAST_SIM(FAST_SIM)
   ) u_timer (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_run    (w_waiting),
      .o_expired(w_expired)
   );

   // Sticky timeout flag, cleared when the next command is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_grant) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   // FAST_SIM only matters when the timeout counter is built.
   logic w_unused_fast_sim;
   assign w_unused_fast_sim = (FAST_SIM != 0) || w_waiting;
   assign w_expired   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Grant / present / wait-for-response sequencing and tour mode tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_NONE;
         r_tour_mode <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_tour) begin
                  r_owner <= OWN_TOUR;
                  r_state <= PRESENT;
               end else if (w_grant_host) begin
                  r_owner <= OWN_HOST;
                  r_state <= PRESENT;
               end
            end
            PRESENT: begin
               if (clr_cmd_rdy) begin
                  // The processor never responds to TOUR_GO, so release at once.
                  if (w_cmd_sel[15:12] == O_TOUR_GO) begin
                     r_owner <= OWN_NONE;
                     r_state <= IDLE;
                  end else begin
                     r_state <= WAIT_RESP;
                  end
               end else if (!w_rdy_sel) begin
                  r_owner <= OWN_NONE;
                  r_state <= IDLE;
               end
            end
            WAIT_RESP: begin
               if (send_resp || w_timeout) begin
                  r_owner <= OWN_NONE;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_owner <= OWN_NONE;
               r_state <= IDLE;
            end
         endcase

         if (w_timeout || tour_done) begin
            r_tour_mode <= 1'b0;
         end else if (tour_go) begin
            r_tour_mode <= 1'b1;
         end
      end
   end

   // Capture the accepted command so the processor sees it stable while it works.
   always_ff @(posedge clk) begin
      if (w_clr_route) begin
         r_cmd_hold <= w_cmd_sel;
      end
   end

   assign cmd              = (r_state == WAIT_RESP) ? r_cmd_hold : w_cmd_sel;
   assign cmd_rdy          = (r_state == PRESENT) && w_rdy_sel;
   assign host_clr_cmd_rdy = w_clr_route && (r_owner == OWN_HOST);
   assign tour_clr_cmd_rdy = w_clr_route && (r_owner == OWN_TOUR);
   assign host_resp        = w_resp_route && (r_owner == OWN_HOST);
   assign tour_resp        = w_resp_route && (r_owner == OWN_TOUR);
   assign owner            = r_owner;
   assign tour_mode        = r_tour_mode;

endmodule

// File: tb/tb_cmd_arb.sv
// tb_cmd_arb: directed bench for cmd_arb with a transaction-level reference
// model compared every cycle. Define CMD_ARB_TIMEOUT_EN to exercise the timeout.
module tb_cmd_arb;

`ifdef CMD_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TMO_LIMIT = 4095;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] host_cmd = '0;
   logic        host_cmd_rdy = 1'b0;
   logic        host_clr_cmd_rdy;
   logic        host_resp;
   logic [15:0] tour_cmd = '0;
   logic        tour_cmd_rdy = 1'b0;
   logic        tour_clr_cmd_rdy;
   logic        tour_resp;
   logic        tour_go = 1'b0;
   logic        tour_done = 1'b0;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        send_resp = 1'b0;
   logic [1:0]  owner;
   logic        tour_mode;
   logic        timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   cmd_arb #(.FAST_SIM(1)) dut (
      .clk             (clk),
      .rst             (rst),
      .host_cmd        (host_cmd),
      .host_cmd_rdy    (host_cmd_rdy),
      .host_clr_cmd_rdy(host_clr_cmd_rdy),
      .host_resp       (host_resp),
      .tour_cmd        (tour_cmd),
      .tour_cmd_rdy    (tour_cmd_rdy),
      .tour_clr_cmd_rdy(tour_clr_cmd_rdy),
      .tour_resp       (tour_resp),
      .tour_go         (tour_go),
      .tour_done       (tour_done),
      .cmd             (cmd),
      .cmd_rdy         (cmd_rdy),
      .clr_cmd_rdy     (clr_cmd_rdy),
      .send_resp       (send_resp),
      .owner           (owner),
      .tour_mode       (tour_mode),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction record (who owns it, whether the
   // processor has accepted it, what was accepted, how long it has waited).
   int          m_owner = 0;
   bit          m_acc   = 1'b0;
   logic [15:0] m_held  = '0;
   bit          m_tour  = 1'b0;
   bit          m_err   = 1'b0;
   int          m_wait  = 0;
   bit          m_expire;

   function automatic logic [15:0] req_cmd(input int who);
      return (who == 1) ? host_cmd : tour_cmd;
   endfunction

   function automatic logic req_rdy(input int who);
      return (who == 1) ? host_cmd_rdy : tour_cmd_rdy;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0;
         m_acc   = 1'b0;
         m_tour  = 1'b0;
         m_err   = 1'b0;
         m_wait  = 0;
      end else begin
         m_expire = 1'b0;
         if (m_owner == 0) begin
            if (m_tour && tour_cmd_rdy) begin
               m_owner = 2; m_acc = 1'b0; m_err = 1'b0;
            end else if (host_cmd_rdy) begin
               m_owner = 1; m_acc = 1'b0; m_err = 1'b0;
            end
         end else if (!m_acc) begin
            if (clr_cmd_rdy) begin
               if (req_cmd(m_owner) >> 12 == 16'h6) begin
                  m_owner = 0;
               end else begin
                  m_acc  = 1'b1;
                  m_held = req_cmd(m_owner);
                  m_wait = 0;
               end
            end else if (!req_rdy(m_owner)) begin
               m_owner = 0;
            end
         end else begin
            if (send_resp) begin
               m_owner = 0;
            end else if (TMO_EN && (m_wait + 1 == TMO_LIMIT)) begin
               m_owner  = 0;
               m_err    = 1'b1;
               m_expire = 1'b1;
            end else begin
               m_wait++;
            end
         end
         if (m_expire || tour_done) m_tour = 1'b0;
         else if (tour_go)          m_tour = 1'b1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [15:0] e_cmd;
      logic        e_present;
      logic        e_waiting;
      e_present = (m_owner != 0) && !m_acc;
      e_waiting = (m_owner != 0) && m_acc;
      if (m_owner == 0)  e_cmd = 16'h0000;
      else if (!m_acc)   e_cmd = req_cmd(m_owner);
      else               e_cmd = m_held;
      chk("m_owner",     16'(owner),            16'(m_owner));
      chk("m_cmd",       cmd,                   e_cmd);
      chk("m_cmd_rdy",   16'(cmd_rdy),          16'(e_present && req_rdy(m_owner)));
      chk("m_host_clr",  16'(host_clr_cmd_rdy), 16'(e_present && m_owner == 1 && clr_cmd_rdy));
      chk("m_tour_clr",  16'(tour_clr_cmd_rdy), 16'(e_present && m_owner == 2 && clr_cmd_rdy));
      chk("m_host_resp", 16'(host_resp),        16'(e_waiting && m_owner == 1 && send_resp));
      chk("m_tour_resp", 16'(tour_resp),        16'(e_waiting && m_owner == 2 && send_resp));
      chk("m_tour_mode", 16'(tour_mode),        16'(m_tour));
      chk("m_tmo_err",   16'(timeout_err),      16'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      step();
      mid();
      chk("rst_owner", 16'(owner), 16'd0);
      chk("rst_cmd", cmd, 16'h0000);
      chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
      chk("rst_tour_mode", 16'(tour_mode), 16'd0);
      chk("rst_tmo", 16'(timeout_err), 16'd0);
      step();
      rst = 1'b0;

      // Host command, outside tour mode, full handshake
      host_cmd = 16'h2000; host_cmd_rdy = 1'b1;
      mid();
      chk("t1_idle_owner", 16'(owner), 16'd0);
      step();
      clr_cmd_rdy = 1'b1;
      mid();
      chk("t1_owner", 16'(owner), 16'd1);
      chk("t1_cmd", cmd, 16'h2000);
      chk("t1_cmd_rdy", 16'(cmd_rdy), 16'd1);
      chk("t1_host_clr", 16'(host_clr_cmd_rdy), 16'd1);
      chk("t1_tour_clr", 16'(tour_clr_cmd_rdy), 16'd0);
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0; host_cmd = 16'hFFFF;
      mid();
      chk("t1_hold_cmd", cmd, 16'h2000);
      chk("t1_wait_rdy", 16'(cmd_rdy), 16'd0);
      repeat (9) step();
      send_resp = 1'b1;
      mid();
      chk("t1_host_resp", 16'(host_resp), 16'd1);
      step();
      send_resp = 1'b0;
      mid();
      chk("t1_done_owner", 16'(owner), 16'd0);
      step();
      send_resp = 1'b1;
      mid();
      chk("idle_resp_drop", 16'(host_resp), 16'd0);
      step();
      send_resp = 1'b0;

      // Tour request ignored outside tour mode; TOUR_GO releases without response
      tour_cmd = 16'h4100; tour_cmd_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         mid();
         chk("t2_tour_ignored", 16'(cmd_rdy), 16'd0);
      end
      step();
      host_cmd = 16'h6000; host_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b1;
      mid();
      chk("t2_go_cmd", cmd, 16'h6000);
      chk("t2_go_clr", 16'(host_clr_cmd_rdy), 16'd1);
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0; tour_go = 1'b1;
      mid();
      chk("t2_go_released", 16'(owner), 16'd0);
      chk("t2_mode_pre", 16'(tour_mode), 16'd0);
      step();
      tour_go = 1'b0;
      mid();
      chk("t2_mode_set", 16'(tour_mode), 16'd1);
      step();
      mid();
      chk("t2_tour_owner", 16'(owner), 16'd2);
      chk("t2_tour_cmd", cmd, 16'h4100);
      step();
      clr_cmd_rdy = 1'b1;
      mid();
      chk("t2_tour_clr", 16'(tour_clr_cmd_rdy), 16'd1);
      chk("t2_host_noclr", 16'(host_clr_cmd_rdy), 16'd0);
      step();
      clr_cmd_rdy = 1'b0; tour_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1;
      mid();
      chk("t2_tour_resp", 16'(tour_resp), 16'd1);
      step();
      send_resp = 1'b0;

      // Tour priority when both request together
      host_cmd = 16'h2000; host_cmd_rdy = 1'b1;
      tour_cmd = 16'h5000; tour_cmd_rdy = 1'b1;
      step();
      mid();
      chk("t3_tour_first", 16'(owner), 16'd2);
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; tour_cmd_rdy = 1'b0;
      mid();
      chk("t3_hold", cmd, 16'h5000);
      step();
      send_resp = 1'b1;
      mid();
      chk("t3_tour_resp", 16'(tour_resp), 16'd1);
      chk("t3_no_host_resp", 16'(host_resp), 16'd0);
      step();
      send_resp = 1'b0;
      step();
      mid();
      chk("t3_host_next", 16'(owner), 16'd1);
      chk("t3_host_cmd", cmd, 16'h2000);
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;

      // Requester withdraws during presentation
      host_cmd = 16'h2200; host_cmd_rdy = 1'b1;
      step();
      step();
      host_cmd_rdy = 1'b0;
      mid();
      chk("t5_drop_rdy", 16'(cmd_rdy), 16'd0);
      step();
      mid();
      chk("t5_drop_idle", 16'(owner), 16'd0);

      // Response and tour_done together
      tour_cmd = 16'h4200; tour_cmd_rdy = 1'b1;
      host_cmd = 16'h2100; host_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; tour_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1; tour_done = 1'b1;
      mid();
      chk("t6_tour_resp", 16'(tour_resp), 16'd1);
      step();
      send_resp = 1'b0; tour_done = 1'b0;
      mid();
      chk("t6_mode_clr", 16'(tour_mode), 16'd0);
      step();
      mid();
      chk("t6_host_grant", 16'(owner), 16'd1);
      chk("t6_host_cmd", cmd, 16'h2100);
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;

      // Reset during WAIT_RESP with the host request still held
      host_cmd = 16'h4021; host_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1; rst = 1'b1;
      mid();
      chk("t4_rst_owner", 16'(owner), 16'd0);
      chk("t4_rst_cmd", cmd, 16'h0000);
      chk("t4_rst_resp", 16'(host_resp), 16'd0);
      step();
      rst = 1'b0; send_resp = 1'b0;
      step();
      mid();
      chk("t4_regrant", 16'(owner), 16'd1);
      chk("t4_regrant_cmd", cmd, 16'h4021);
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;

`ifdef CMD_ARB_TIMEOUT_EN
      // Timeout: no response ever arrives
      tour_go = 1'b1;
      step();
      tour_go = 1'b0;
      host_cmd = 16'h2000; host_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0;
      mid();
      chk("t7_no_tmo_yet", 16'(timeout_err), 16'd0);
      repeat (TMO_LIMIT - 1) step();
      mid();
      chk("t7_last_wait", 16'(owner), 16'd1);
      step();
      mid();
      chk("t7_tmo_err", 16'(timeout_err), 16'd1);
      chk("t7_tmo_owner", 16'(owner), 16'd0);
      chk("t7_tmo_mode", 16'(tour_mode), 16'd0);
      host_cmd_rdy = 1'b1;
      step();
      mid();
      chk("t7_err_cleared", 16'(timeout_err), 16'd0);
      chk("t7_regrant", 16'(owner), 16'd1);
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0; host_cmd_rdy = 1'b0;
      step();
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
`else
      mid();
      chk("t7_tmo_tied", 16'(timeout_err), 16'd0);
`endif

      step();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_arb.md
Name: cmd_arb

Overview:
- Arbiter between the two command sources in the Knight design, the host wrapper (UART/BLE) and the tour command generator, and the single command port of the command processor.
- Grants the processor to one requester at a time and holds that grant from command presentation through completion.
- Routes the processor's clr_cmd_rdy and send_resp back to the owning requester.
- Tracks tour mode, entered on tour_go and left on tour_done, and blocks stray requests according to the rules below.

Parameters:
- FAST_SIM, 1: selects the timeout limit. 1 gives 4095 cycles; 0 gives 2^26-1 cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- host_cmd  in  16  command from host wrapper
- host_cmd_rdy  in  1  host command valid; held until cleared
- host_clr_cmd_rdy  out  1  clears host_cmd_rdy
- host_resp  out  1  one-cycle pulse: host command completed
- tour_cmd  in  16  command from tour generator
- tour_cmd_rdy  in  1  tour command valid; held until cleared
- tour_clr_cmd_rdy  out  1  clears tour_cmd_rdy
- tour_resp  out  1  one-cycle pulse: tour command completed
- tour_go  in  1  pulse from command processor; enter tour mode
- tour_done  in  1  pulse from tour generator; leave tour mode
- cmd  out  16  command to command processor
- cmd_rdy  out  1  command valid to command processor
- clr_cmd_rdy  in  1  command processor accepted cmd
- send_resp  in  1  command processor finished cmd
- owner  out  2  00 none, 01 host, 10 tour
- tour_mode  out  1  tour mode flag
- timeout_err  out  1  sticky: an outstanding command timed out

Behaviour:
- Reset (async, rst=1):
  - state IDLE; owner=00; tour_mode=0; timeout_err=0.
  - cmd=0; cmd_rdy, host_clr_cmd_rdy, tour_clr_cmd_rdy, host_resp and tour_resp all 0.
  - Reset mid-transaction abandons the grant silently; no resp pulse is issued.
- States (registered): IDLE, PRESENT, WAIT_RESP.
- IDLE eligibility and grant:
  - tour_mode=0: only the host is eligible; tour_cmd_rdy is ignored and left pending.
  - tour_mode=1: tour has fixed priority; the host is granted only if tour_cmd_rdy=0.
  - An eligible request seen in cycle N registers owner in N and moves to PRESENT at N+1.
- PRESENT:
  - cmd is the owner's cmd, combinational mux on registered owner; cmd_rdy = owner's cmd_rdy.
  - clr_cmd_rdy is passed combinationally to the owner's clr output and to no other requester.
  - On clr_cmd_rdy, if cmd[15:12]==4'b0110 (TOUR_GO), go to IDLE next cycle with no resp, since the processor never responds to this opcode. Otherwise go to WAIT_RESP.
- WAIT_RESP:
  - cmd is held at its last value and cmd_rdy=0.
  - On send_resp, pulse the owner's resp in the same cycle (combinational route), clear owner to 00 and go to IDLE next cycle.
  - send_resp in IDLE or PRESENT is dropped.
- cmd output when owner=00: 16'h0000.
- tour_mode:
  - Set on tour_go, cleared on tour_done; tour_done wins if both occur in one cycle.
  - Changes take effect on the next IDLE arbitration, never on a live grant.
- Simultaneous send_resp and tour_done: both take effect. A new grant is possible in the next IDLE cycle, so minimum back-to-back spacing is 3 cycles (grant, present, complete).
- Owner request dropped during PRESENT (cmd_rdy falls without clr): return to IDLE next cycle.

Optional Feature:
- Macro: CMD_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RESP and clears on entry.
  - When it reaches the limit (4095 if FAST_SIM else 2^26-1): set timeout_err, clear owner and tour_mode, go to IDLE, issue no resp.
  - timeout_err clears on the next grant.
- Undefined: no counter; timeout_err is tied 0; WAIT_RESP waits indefinitely.

Decomposition:
- Shared package cmd_arb_pkg:
  - state enum {IDLE, PRESENT, WAIT_RESP}
  - owner enum {OWN_NONE, OWN_HOST, OWN_TOUR}
  - opcode localparams O_CALIBRATE=4'b0010, O_MOVE=4'b0100, O_MOVE_F=4'b0101, O_TOUR_GO=4'b0110, reused by the command processor
- Sub-module: cmd_arb_timer, the parameterised timeout counter, instantiated only under CMD_ARB_TIMEOUT_EN.

Test Plan:
- Host cmd 16'h2000, tour_mode=0 -> owner=01 next cycle, cmd=16'h2000 with cmd_rdy=1. Proc clr -> host_clr=1 same cycle. send_resp 10 cycles later -> host_resp pulse, owner=00.
- tour_cmd_rdy=1 with tour_mode=0 -> never granted, cmd_rdy stays 0. Then host 16'h6000 -> clr, IDLE with no resp; tour_go pulse -> tour_mode=1; pending tour cmd granted 2 cycles later.
- tour_mode=1 with host and tour both ready in the same cycle -> tour granted first; host granted after tour_resp.
- Host cmd 16'h4021 in WAIT_RESP, rst asserted for 1 cycle -> all outputs 0 immediately and no host_resp; after release the held host_cmd_rdy is re-granted.
- CMD_ARB_TIMEOUT_EN, FAST_SIM=1, no send_resp -> 4095 cycles into WAIT_RESP timeout_err=1, owner=00, tour_mode=0. Next grant clears timeout_err.
- send_resp and tour_done in the same cycle while owner=10 -> tour_resp pulse, tour_mode=0, pending host granted.
